// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: control field positions,
// ALU op encodings, R-type function codes and multiply/divide op codes.
package ex_pkg;

    localparam int EX_REG_DST    = 3;
    localparam int EX_ALU_HI     = 2;
    localparam int EX_ALU_LO     = 1;
    localparam int EX_ALU_SRC    = 0;
    localparam int M_BRANCH      = 2;
    localparam int M_MEM_READ    = 1;
    localparam int M_MEM_WRITE   = 0;
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    // Low two funct bits of 18h..1Bh map directly onto this encoding
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative shift-add multiplier / restoring divider owning HI and LO.
// Signed ops iterate on magnitudes; the sign is applied on the last step.
module ex_muldiv
    import ex_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  md_op_e           i_md_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_hi_we,
    input  logic             i_lo_we,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(MD_CYCLES + 1);

    logic [CW-1:0]      r_cnt;
    logic               r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mq;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_amag;
    logic [WIDTH-1:0]   w_bmag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_t;
    logic               w_ge;
    logic [WIDTH-1:0]   w_acc_n;
    logic [WIDTH-1:0]   w_mq_n;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic [2*WIDTH-1:0] w_prod;

    assign o_busy   = (r_cnt != '0);
    assign o_hi     = r_hi;
    assign o_lo     = r_lo;
    assign w_signed = (i_md_op == MD_MULT) || (i_md_op == MD_DIV);
    assign w_sa     = w_signed & i_a[WIDTH-1];
    assign w_sb     = w_signed & i_b[WIDTH-1];
    assign w_amag   = w_sa ? -i_a : i_a;
    assign w_bmag   = w_sb ? -i_b : i_b;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_b};
    assign w_t   = {r_acc, r_mq[WIDTH-1]};
    assign w_ge  = (w_t >= {1'b0, r_b});

    always_comb begin
        w_acc_n = '0;
        w_mq_n  = '0;
        if (r_div) begin
            w_acc_n = w_ge ? (w_t[WIDTH-1:0] - r_b) : w_t[WIDTH-1:0];
            w_mq_n  = {r_mq[WIDTH-2:0], w_ge};
        end else if (r_mq[0]) begin
            w_acc_n = w_sum[WIDTH:1];
            w_mq_n  = {w_sum[0], r_mq[WIDTH-1:1]};
        end else begin
            w_acc_n = {1'b0, r_acc[WIDTH-1:1]};
            w_mq_n  = {r_acc[0], r_mq[WIDTH-1:1]};
        end
    end

    // Divide by zero: quotient all ones, remainder is the dividend
    assign w_prod = r_neg_q ? -{w_acc_n, w_mq_n} : {w_acc_n, w_mq_n};
    assign w_q    = r_dz ? '1 : (r_neg_q ? -w_mq_n : w_mq_n);
    assign w_r    = r_neg_r ? -w_acc_n : w_acc_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_acc   <= '0;
            r_mq    <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            if (i_start && !o_busy) begin
                r_cnt   <= CW'(MD_CYCLES);
                r_div   <= (i_md_op == MD_DIV) || (i_md_op == MD_DIVU);
                r_neg_q <= w_sa ^ w_sb;
                r_neg_r <= w_sa;
                r_dz    <= (i_b == '0);
                r_acc   <= '0;
                r_mq    <= w_amag;
                r_b     <= w_bmag;
            end else if (o_busy) begin
                r_cnt <= r_cnt - CW'(1);
                r_acc <= w_acc_n;
                r_mq  <= w_mq_n;
                if (r_cnt == CW'(1)) begin
                    if (r_div) begin
                        r_hi <= w_r;
                        r_lo <= w_q;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
            end
            if (i_hi_we) r_hi <= i_wdata;
            if (i_lo_we) r_lo <= i_wdata;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS R2000 execute stage: ALU, shifter, destination select, HI/LO
// multiply/divide and the EX/MEM pipeline register.
module ex_stage
    import ex_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       i_ex,
    input  logic [2:0]       i_m,
    input  logic [1:0]       i_wb,
    input  logic [4:0]       i_rt,
    input  logic [4:0]       i_rd,
    input  logic [WIDTH-1:0] i_imm,
    input  logic [WIDTH-1:0] i_data_1,
    input  logic [WIDTH-1:0] i_data_2,
    input  logic [WIDTH-1:0] i_pc_branch,
    output logic [WIDTH-1:0] o_alu_result,
    output logic             o_zero,
    output logic [WIDTH-1:0] o_mem_wdata,
    output logic [4:0]       o_write_register,
    output logic [2:0]       o_m_out,
    output logic [1:0]       o_wb_out,
    output logic [WIDTH-1:0] o_pc_branch_out,
    output logic             o_overflow,
    output logic             o_stall
);

    logic [1:0]       w_alu_op;
    logic [5:0]       w_funct;
    logic [4:0]       w_shamt;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_ovf;
    logic             w_kill_wb;
    logic             w_md;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_hilo;
    logic             w_busy;
    logic             w_stall;

    logic [WIDTH-1:0] r_alu_result;
    logic             r_zero;
    logic [WIDTH-1:0] r_mem_wdata;
    logic [4:0]       r_write_register;
    logic [2:0]       r_m;
    logic [1:0]       r_wb;
    logic [WIDTH-1:0] r_pc_branch;
    logic             r_overflow;

    assign w_alu_op = i_ex[EX_ALU_HI:EX_ALU_LO];
    assign w_funct  = i_imm[5:0];
    assign w_shamt  = i_imm[10:6];
    assign w_b      = i_ex[EX_ALU_SRC] ? i_imm : i_data_2;
    assign w_sum    = i_data_1 + w_b;
    assign w_diff   = i_data_1 - w_b;

    assign w_add_ovf = (i_data_1[WIDTH-1] == w_b[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != i_data_1[WIDTH-1]);
    assign w_sub_ovf = (i_data_1[WIDTH-1] != w_b[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != i_data_1[WIDTH-1]);

    always_comb begin
        w_result  = w_sum;
        w_ovf     = 1'b0;
        w_kill_wb = 1'b0;
        w_md      = 1'b0;
        w_mthi    = 1'b0;
        w_mtlo    = 1'b0;
        w_hilo    = 1'b0;
        case (w_alu_op)
            ALU_SUB: w_result = w_diff;
            ALU_FUNCT: begin
                case (w_funct)
                    F_ADD: begin
                        w_ovf     = w_add_ovf;
                        w_kill_wb = w_add_ovf;
                    end
                    F_ADDU: w_result = w_sum;
                    F_SUB: begin
                        w_result  = w_diff;
                        w_ovf     = w_sub_ovf;
                        w_kill_wb = w_sub_ovf;
                    end
                    F_SUBU: w_result = w_diff;
                    F_AND:  w_result = i_data_1 & w_b;
                    F_OR:   w_result = i_data_1 | w_b;
                    F_XOR:  w_result = i_data_1 ^ w_b;
                    F_NOR:  w_result = ~(i_data_1 | w_b);
                    F_SLT: w_result = {{(WIDTH-1){1'b0}},
                                       $signed(i_data_1) < $signed(w_b)};
                    F_SLTU: w_result = {{(WIDTH-1){1'b0}}, i_data_1 < w_b};
                    F_SLL:  w_result = i_data_2 << w_shamt;
                    F_SRL:  w_result = i_data_2 >> w_shamt;
                    F_SRA:  w_result = $signed(i_data_2) >>> w_shamt;
                    F_MFHI: begin
                        w_result = w_hi;
                        w_hilo   = 1'b1;
                    end
                    F_MFLO: begin
                        w_result = w_lo;
                        w_hilo   = 1'b1;
                    end
                    F_MTHI: begin
                        w_mthi    = 1'b1;
                        w_hilo    = 1'b1;
                        w_kill_wb = 1'b1;
                    end
                    F_MTLO: begin
                        w_mtlo    = 1'b1;
                        w_hilo    = 1'b1;
                        w_kill_wb = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        w_md      = 1'b1;
                        w_hilo    = 1'b1;
                        w_kill_wb = 1'b1;
                    end
                    default: begin
                        w_result  = '0;
                        w_kill_wb = 1'b1;
                    end
                endcase
            end
            default: w_result = w_sum;
        endcase
    end

    assign w_stall = w_busy & w_hilo;
    assign o_stall = w_stall;

    ex_muldiv #(
        .WIDTH    (WIDTH),
        .MD_CYCLES(MD_CYCLES)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_md),
        .i_md_op(md_op_e'(w_funct[1:0])),
        .i_a    (i_data_1),
        .i_b    (i_data_2),
        .i_hi_we(w_mthi & ~w_busy),
        .i_lo_we(w_mtlo & ~w_busy),
        .i_wdata(i_data_1),
        .o_busy (w_busy),
        .o_hi   (w_hi),
        .o_lo   (w_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_result     <= '0;
            r_zero           <= 1'b0;
            r_mem_wdata      <= '0;
            r_write_register <= '0;
            r_m              <= '0;
            r_wb             <= '0;
            r_pc_branch      <= '0;
            r_overflow       <= 1'b0;
        end else begin
            r_alu_result     <= w_result;
            r_zero           <= (w_result == '0);
            r_mem_wdata      <= i_data_2;
            r_write_register <= i_ex[EX_REG_DST] ? i_rd : i_rt;
            r_m              <= (w_stall || w_md) ? '0 : i_m;
            r_wb             <= (w_stall || w_kill_wb) ? '0 : i_wb;
            r_pc_branch      <= i_pc_branch;
            r_overflow       <= w_ovf & ~w_stall;
        end
    end

    assign o_alu_result     = r_alu_result;
    assign o_zero           = r_zero;
    assign o_mem_wdata      = r_mem_wdata;
    assign o_write_register = r_write_register;
    assign o_m_out          = r_m;
    assign o_wb_out         = r_wb;
    assign o_pc_branch_out  = r_pc_branch;
    assign o_overflow       = r_overflow;

endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized bench for ex_stage against a behavioural model.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  i_ex;
    logic [2:0]  i_m;
    logic [1:0]  i_wb;
    logic [4:0]  i_rt;
    logic [4:0]  i_rd;
    logic [31:0] i_imm;
    logic [31:0] i_data_1;
    logic [31:0] i_data_2;
    logic [31:0] i_pc_branch;
    logic [31:0] o_alu_result;
    logic        o_zero;
    logic [31:0] o_mem_wdata;
    logic [4:0]  o_write_register;
    logic [2:0]  o_m_out;
    logic [1:0]  o_wb_out;
    logic [31:0] o_pc_branch_out;
    logic        o_overflow;
    logic        o_stall;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] mhi = 32'h0;
    logic [31:0] mlo = 32'h0;
    logic [5:0]  ftab [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                               6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02,
                               6'h03, 6'h10, 6'h12, 6'h3F};

    always #5 clk = ~clk;

    ex_stage #(
        .WIDTH    (32),
        .MD_CYCLES(32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_ex            (i_ex),
        .i_m             (i_m),
        .i_wb            (i_wb),
        .i_rt            (i_rt),
        .i_rd            (i_rd),
        .i_imm           (i_imm),
        .i_data_1        (i_data_1),
        .i_data_2        (i_data_2),
        .i_pc_branch     (i_pc_branch),
        .o_alu_result    (o_alu_result),
        .o_zero          (o_zero),
        .o_mem_wdata     (o_mem_wdata),
        .o_write_register(o_write_register),
        .o_m_out         (o_m_out),
        .o_wb_out        (o_wb_out),
        .o_pc_branch_out (o_pc_branch_out),
        .o_overflow      (o_overflow),
        .o_stall         (o_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ex, input logic [2:0] m,
                         input logic [1:0] wb, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] imm,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] pc);
        i_ex = ex; i_m = m; i_wb = wb; i_rt = rt; i_rd = rd;
        i_imm = imm; i_data_1 = d1; i_data_2 = d2; i_pc_branch = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_res"}, o_alu_result, 32'h0);
        check({tag, "_zero"}, o_zero, 32'h0);
        check({tag, "_wdata"}, o_mem_wdata, 32'h0);
        check({tag, "_wreg"}, o_write_register, 32'h0);
        check({tag, "_m"}, o_m_out, 32'h0);
        check({tag, "_wb"}, o_wb_out, 32'h0);
        check({tag, "_pc"}, o_pc_branch_out, 32'h0);
        check({tag, "_ovf"}, o_overflow, 32'h0);
        check({tag, "_stall"}, o_stall, 32'h0);
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 4))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    // Reference: signed results from 64-bit arithmetic, range test for overflow
    task automatic alu_model(input logic [3:0] ex, input logic [2:0] m,
                             input logic [1:0] wb, input logic [31:0] imm,
                             input logic [31:0] d1, input logic [31:0] d2,
                             output logic [31:0] res, output logic [1:0] wbo,
                             output logic [2:0] mo, output logic ovf);
        logic [31:0] b;
        logic [4:0]  sh;
        longint      s;
        b   = ex[0] ? imm : d2;
        sh  = imm[10:6];
        res = d1 + b;
        wbo = wb;
        mo  = m;
        ovf = 1'b0;
        if (ex[2:1] == 2'b01) res = d1 - b;
        if (ex[2:1] == 2'b10) begin
            case (imm[5:0])
                6'h20, 6'h22: begin
                    if (imm[5:0] == 6'h20) begin
                        s = longint'($signed(d1)) + longint'($signed(b));
                        res = d1 + b;
                    end else begin
                        s = longint'($signed(d1)) - longint'($signed(b));
                        res = d1 - b;
                    end
                    ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                    if (ovf) wbo = 2'b00;
                end
                6'h21: res = d1 + b;
                6'h23: res = d1 - b;
                6'h24: res = d1 & b;
                6'h25: res = d1 | b;
                6'h26: res = d1 ^ b;
                6'h27: res = ~(d1 | b);
                6'h2A: res = ($signed(d1) < $signed(b)) ? 32'd1 : 32'd0;
                6'h2B: res = (d1 < b) ? 32'd1 : 32'd0;
                6'h00: res = d2 << sh;
                6'h02: res = d2 >> sh;
                6'h03: res = $signed(d2) >>> sh;
                6'h10: res = mhi;
                6'h12: res = mlo;
                default: begin
                    res = 32'h0;
                    wbo = 2'b00;
                end
            endcase
        end
    endtask

    task automatic md_model(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, output logic [31:0] hi,
                            output logic [31:0] lo);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = 32'h0;
        lo = 32'h0;
        case (op)
            2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'd1: begin
                p = {32'h0, a} * {32'h0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            2'd2: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFF_FFFF; hi = a;
                end else begin
                    p = sa / sb; lo = p[31:0];
                    p = sa % sb; hi = p[31:0];
                end
            end
            default: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFF_FFFF; hi = a;
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endtask

    task automatic md_run(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input bit gap);
        int n;
        logic [31:0] x;
        logic [31:0] y;
        drive(4'b1100, 3'b011, 2'b10, 5'd2, 5'd3, 32'h18 + {30'd0, op},
              a, b, 32'h0);
        #1 check("md_accept_stall", o_stall, 32'h0);
        tick();
        check("md_bubble_wb", o_wb_out, 32'h0);
        check("md_bubble_m", o_m_out, 32'h0);
        if (gap) begin
            x = $urandom;
            y = $urandom;
            drive(4'b1100, 3'b000, 2'b10, 5'd2, 5'd7, 32'h21, x, y, 32'h0);
            #1 check("busy_alu_stall", o_stall, 32'h0);
            tick();
            check("busy_alu_res", o_alu_result, x + y);
            check("busy_alu_wb", o_wb_out, 32'h2);
        end
        drive(4'b1100, 3'b000, 2'b10, 5'd2, 5'd8, 32'h12, 32'h0, 32'h0, 32'h0);
        #1;
        n = 0;
        while (o_stall === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("md_stall_cycles", n, gap ? 32'd31 : 32'd32);
        tick();
        check("md_lo", o_alu_result, elo);
        check("md_lo_wb", o_wb_out, 32'h2);
        drive(4'b1100, 3'b000, 2'b10, 5'd2, 5'd8, 32'h10, 32'h0, 32'h0, 32'h0);
        #1 check("mfhi_stall", o_stall, 32'h0);
        tick();
        check("md_hi", o_alu_result, ehi);
        mhi = ehi;
        mlo = elo;
    endtask

    initial begin
        logic [3:0]  ex;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] pc;
        logic [31:0] eres;
        logic [1:0]  ewb;
        logic [2:0]  em;
        logic        eovf;
        logic [31:0] eh;
        logic [31:0] el;
        logic [1:0]  op;
        int          k;

        rst = 1'b1;
        drive(4'h0, 3'h0, 2'h0, 5'h0, 5'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        check_zero_outputs("reset");
        rst = 1'b0;

        drive(4'b1100, 3'b000, 2'b10, 5'd3, 5'd4, 32'h20,
              32'h7FFF_FFFF, 32'h1, 32'h0);
        tick();
        check("add_ovf", o_overflow, 32'h1);
        check("add_wb", o_wb_out, 32'h0);
        check("add_res", o_alu_result, 32'h8000_0000);
        drive(4'b1100, 3'b000, 2'b10, 5'd3, 5'd4, 32'h21,
              32'h7FFF_FFFF, 32'h1, 32'h0);
        tick();
        check("addu_ovf", o_overflow, 32'h0);
        check("addu_wb", o_wb_out, 32'h2);
        check("addu_res", o_alu_result, 32'h8000_0000);
        check("addu_wreg", o_write_register, 32'd4);

        drive(4'b0001, 3'b010, 2'b11, 5'd9, 5'd0, 32'h10,
              32'h1000, 32'hABCD, 32'h400);
        tick();
        check("lw_res", o_alu_result, 32'h1010);
        check("lw_wreg", o_write_register, 32'd9);
        check("lw_m", o_m_out, 32'h2);
        check("lw_wb", o_wb_out, 32'h3);
        check("lw_wdata", o_mem_wdata, 32'hABCD);
        check("lw_pc", o_pc_branch_out, 32'h400);

        drive(4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 32'h103,
              32'h0, 32'h8000_0000, 32'h0);
        tick();
        check("sra_res", o_alu_result, 32'hF800_0000);
        drive(4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 32'h2A,
              32'hFFFF_FFFF, 32'h1, 32'h0);
        tick();
        check("slt_res", o_alu_result, 32'h1);
        drive(4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 32'h2B,
              32'hFFFF_FFFF, 32'h1, 32'h0);
        tick();
        check("sltu_res", o_alu_result, 32'h0);
        check("sltu_zero", o_zero, 32'h1);
        drive(4'b0010, 3'b100, 2'b00, 5'd1, 5'd2, 32'h8,
              32'h55, 32'h55, 32'h1234);
        tick();
        check("beq_zero", o_zero, 32'h1);
        check("beq_m", o_m_out, 32'h4);
        check("beq_pc", o_pc_branch_out, 32'h1234);

        drive(4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 32'h11,
              32'h1234_5678, 32'h0, 32'h0);
        tick();
        check("mthi_wb", o_wb_out, 32'h0);
        drive(4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 32'h13,
              32'h9ABC_DEF0, 32'h0, 32'h0);
        tick();
        drive(4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 32'h10,
              32'h0, 32'h0, 32'h0);
        tick();
        check("mthi_read", o_alu_result, 32'h1234_5678);
        drive(4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 32'h12,
              32'h0, 32'h0, 32'h0);
        tick();
        check("mtlo_read", o_alu_result, 32'h9ABC_DEF0);

        md_run(2'd0, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        md_run(2'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        md_run(2'd3, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF, 1'b1);

        for (int i = 0; i < 6; i++) begin
            op = 2'($urandom_range(0, 3));
            d1 = rnd_op();
            d2 = ($urandom_range(0, 4) == 0) ? 32'h0 : rnd_op();
            md_model(op, d1, d2, eh, el);
            md_run(op, d1, d2, eh, el, 1'b1);
        end

        drive(4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 32'h1B,
              32'd1000, 32'd7, 32'h0);
        tick();
        drive(4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 32'h12,
              32'h0, 32'h0, 32'h0);
        repeat (10) tick();
        check("divu_busy_stall", o_stall, 32'h1);
        rst = 1'b1;
        tick();
        check_zero_outputs("midreset");
        rst = 1'b0;
        tick();
        check("reset_lo", o_alu_result, 32'h0);
        check("reset_lo_wb", o_wb_out, 32'h2);
        drive(4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 32'h10,
              32'h0, 32'h0, 32'h0);
        tick();
        check("reset_hi", o_alu_result, 32'h0);
        mhi = 32'h0;
        mlo = 32'h0;

        md_model(2'd1, 32'hDEAD_BEEF, 32'h1234_5678, eh, el);
        md_run(2'd1, 32'hDEAD_BEEF, 32'h1234_5678, eh, el, 1'b1);

        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 19);
            if (k < 16) begin
                ex  = 4'b1100;
                imm = {16'h0, 5'($urandom), 5'($urandom), ftab[k]};
            end else begin
                case (k - 16)
                    1: ex = {1'($urandom), 2'b01, 1'($urandom)};
                    2: ex = {1'($urandom), 2'b11, 1'($urandom)};
                    default: ex = {1'($urandom), 2'b00, 1'($urandom)};
                endcase
                imm = {16'h0, 16'($urandom)};
            end
            m  = 3'($urandom);
            wb = 2'($urandom);
            rt = 5'($urandom);
            rd = 5'($urandom);
            d1 = rnd_op();
            d2 = rnd_op();
            pc = $urandom;
            alu_model(ex, m, wb, imm, d1, d2, eres, ewb, em, eovf);
            drive(ex, m, wb, rt, rd, imm, d1, d2, pc);
            tick();
            check("rnd_res", o_alu_result, eres);
            check("rnd_zero", o_zero, {31'h0, eres == 32'h0});
            check("rnd_wb", o_wb_out, {30'h0, ewb});
            check("rnd_m", o_m_out, {29'h0, em});
            check("rnd_ovf", o_overflow, {31'h0, eovf});
            check("rnd_wreg", o_write_register, {27'h0, ex[3] ? rd : rt});
            check("rnd_wdata", o_mem_wdata, d2);
            check("rnd_pc", o_pc_branch_out, pc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS R2000 pipeline.
- Sits directly downstream of ID and consumes its registered control bundles (ex/m/wb) and operands.
- Performs ALU operations, shifts, destination-register selection and an iterative HI/LO multiply/divide.
- Drives the EX/MEM pipeline register toward the memory stage and raises a stall toward ID/IF.

Parameters:
- WIDTH, 32, datapath width.
- MD_CYCLES, 32, iterations per multiply/divide; must equal WIDTH.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- ex  in  4  [3]=reg_dst, [2:1]=alu_op (00 add, 01 sub, 10 funct, 11 rsvd→add), [0]=alu_src
- m  in  3  [2]=branch, [1]=mem_read, [0]=mem_write
- wb  in  2  [1]=reg_write, [0]=mem_to_reg
- rt, rd  in  5  register specifiers from ID
- imm  in  32  zero-extended inst[15:0]; funct=imm[5:0], shamt=imm[10:6]
- data_1, data_2  in  32  rs/rt operand values
- pc_branch  in  32  branch target from ID
- alu_result  out  32  registered ALU/HI/LO result
- zero  out  1  registered (alu_result==0)
- mem_wdata  out  32  registered data_2
- write_register  out  5  registered rd if reg_dst, else rt
- m_out  out  3  registered m
- wb_out  out  2  registered wb
- pc_branch_out  out  32  registered pc_branch
- overflow  out  1  registered 1-cycle pulse on signed add/sub overflow
- stall  out  1  combinational; ID/IF must hold inputs stable while high

Behaviour:
- Reset (sync, rst=1 at edge): all registered outputs = 0, HI = LO = 0, md counter = 0, busy = 0. A reset mid-operation aborts any mult/div and leaves HI/LO at 0.
- Operand B = alu_src ? imm : data_2.
- alu_op=10 decodes funct:
  - add/sub (20/22h) are signed and set overflow.
  - addu/subu (21/23h), and/or/xor/nor (24–27h), slt (2Ah, signed), sltu (2Bh).
  - sll/srl/sra (00/02/03h) shift data_2 by shamt.
  - mfhi/mflo (10h/12h) give HI/LO.
  - mthi/mtlo (11h/13h) write data_1 to HI/LO at the edge; they write no GPR (wb_out forced 0).
  - Unknown funct → result 0, wb_out forced 0.
- Latency: 1 cycle, input to EX/MEM outputs.
- Overflow on add/sub: overflow=1 for one cycle, wb_out=0 (register write suppressed), alu_result = wrapped sum.
- Mult/div (18h–1Bh):
  - Accepted at edge T when not busy. The instruction passes to EX/MEM as a bubble (wb_out=0, m_out=0).
  - busy=1 for cycles T+1..T+MD_CYCLES. HI/LO update at the end of the last iteration, and busy=0 from T+MD_CYCLES+1.
  - Signed ops run on magnitudes with the sign fixed on the final cycle.
  - div: LO=quotient, HI=remainder; the remainder takes the dividend's sign.
  - Divide by zero: LO=FFFF_FFFFh, HI=dividend; normal latency; no exception.
- stall=1 when busy and the EX instruction is mfhi, mflo, mthi, mtlo, mult or div. While stalled, the EX/MEM register loads a bubble (m_out=0, wb_out=0, overflow=0, other outputs don't-care).
- mthi/mtlo and a completing iteration in the same cycle cannot occur, because stall excludes it.
- Non-HI/LO instructions proceed normally while busy.

Decomposition:
- Package ex_pkg holds:
  - funct constants (F_ADD…F_DIVU, F_MFHI…)
  - alu_op enum (ALU_ADD, ALU_SUB, ALU_FUNCT)
  - bit-index constants for the ex/m/wb fields
  - md_op enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
- Sub-module ex_muldiv holds the iterative shift-add multiplier and restoring divider.
  - Interface: start, md_op, a, b in; busy, hi, lo out.
  - It also owns the HI/LO registers and the mthi/mtlo write ports.

Test Plan:
- add with data_1=7FFF_FFFFh, data_2=1 → overflow=1, wb_out=00, alu_result=8000_0000h; addu with the same operands → overflow=0, wb_out=ex wb.
- lw (ex=0001, imm=0010h, data_1=1000h) → alu_result=1010h, write_register=rt, m_out=010, one cycle later.
- mult FFFF_FFFEh×3 then mflo the next cycle → stall high for 32 cycles; mflo then returns FFFF_FFFAh and mfhi returns FFFF_FFFFh.
- div −7/2 → LO=FFFF_FFFDh, HI=FFFF_FFFFh. divu 5/0 → LO=FFFF_FFFFh, HI=5.
- rst asserted at iteration 10 of divu → next cycle busy=0, stall=0, HI=LO=0, all outputs 0.
- sra data_2=8000_0000h, shamt=4 → F800_0000h. slt −1<1 → 1. sltu FFFF_FFFFh<1 → 0. beq with equal operands → zero=1, m_out=100.
